reg_write_scoreboard: RTL and testbench
=======================================

Name: reg_write_scoreboard

Overview:
- Parametrised successor to the per-instruction "writes rd" decode check.
- Tracks outstanding destination-register writes for in-flight instructions, with a saturating counter per architectural register.
- Sits between decode/issue and writeback; issue uses rs1_busy/rs2_busy to stall RAW hazards.
- Supports multiple in-flight writes to the same rd, optional same-cycle writeback bypass, flush, and an underflow error flag.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero and never tracked.
- CNT_W, 2, width of each per-register pending counter; max outstanding writes per register = 2^CNT_W-1.
- BYPASS_WB, 1, when 1 a same-cycle writeback that drops a count to 0 makes the register report not busy in that cycle.
- AW, $clog2(NREG), register index width (derived, not overridden).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- issue_valid  input  1  an instruction issues this cycle
- issue_wen  input  1  issuing instruction writes rd (is_write_reg result)
- issue_rd  input  AW  destination register of issuing instruction
- issue_ready  output  1  issue accepted; low when the issue_rd counter is saturated
- wb_valid  input  1  a register write retires this cycle
- wb_rd  input  AW  register being written back
- flush  input  1  squash all outstanding writes
- rs1  input  AW  source register 1 query
- rs2  input  AW  source register 2 query
- rs1_busy  output  1  rs1 has an outstanding write
- rs2_busy  output  1  rs2 has an outstanding write
- pending_total  output  CNT_W+AW  sum of all per-register counters
- underflow_err  output  1  sticky: writeback hit a register with count 0

Behaviour:
- State: cnt[1..NREG-1] (CNT_W bits each), pending_total register, underflow_err register. reg 0 has no storage.
- Reset (async, active-high): all cnt=0, pending_total=0, underflow_err=0. Outputs during/after reset: rs1_busy=rs2_busy=0, issue_ready=1.
- issue_fire = issue_valid & issue_wen & issue_ready & (issue_rd!=0).
- issue_ready (combinational) = !(issue_valid & issue_wen & issue_rd!=0 & cnt[issue_rd]==max & !(wb_valid & wb_rd==issue_rd)). A same-cycle writeback to the saturated register frees a slot.
- wb_fire = wb_valid & (wb_rd!=0) & (cnt[wb_rd]!=0).
- wb_valid to rd!=0 with cnt==0: no counter change; underflow_err set to 1 on next edge. The flag is sticky until reset.
- Per-register next state at each rising edge:
  - issue_fire only: +1
  - wb_fire only: -1
  - both to same register: unchanged
- pending_total tracks the net change: +1 per issue_fire, -1 per wb_fire. It always equals the sum of cnt.
- flush (priority over issue/wb in the same cycle): all cnt=0, pending_total=0. issue/wb in the flush cycle are discarded; underflow_err is not set by a flush-cycle writeback. Writebacks arriving after flush for squashed instructions must be gated upstream; otherwise they set underflow_err.
- rsX_busy (combinational, zero latency):
  - rsX==0: always 0.
  - BYPASS_WB=0: busy = cnt[rsX]!=0.
  - BYPASS_WB=1: busy = cnt[rsX]!=0 & !(wb_valid & wb_rd==rsX & cnt[rsX]==1).
  - Same-cycle issue to rsX does not affect busy this cycle; it is visible next cycle.
- Issue of rd=0 or issue_wen=0: no state change, issue_ready=1.
- Counter never wraps: saturation is enforced by issue_ready, and underflow by the cnt!=0 check.

Test Plan:
- Reset mid-run: cnt[5]=2, assert reset asynchronously between edges -> rs1_busy(rs1=5) drops to 0 immediately; pending_total=0, underflow_err=0.
- Basic RAW: issue rd=7 at cycle 0, rs1=7 at cycle 1 -> rs1_busy=1; wb rd=7 at cycle 3 -> BYPASS_WB=1: rs1_busy=0 in cycle 3; BYPASS_WB=0: rs1_busy=0 from cycle 4.
- Saturation (CNT_W=2): issue rd=3 three times -> pending_total=3; fourth issue -> issue_ready=0, count stays 3; fourth issue with same-cycle wb rd=3 -> issue_ready=1, count stays 3.
- x0 and non-writing ops: issue rd=0, then issue_wen=0 with rd=4 -> no counter change, issue_ready=1, rs1=0/4 busy=0.
- Simultaneous issue+wb same reg with cnt[9]=1 -> cnt[9] stays 1, pending_total unchanged; different regs (issue 9, wb 10) -> cnt[9]+1, cnt[10]-1.
- Flush and underflow: cnt[2]=1, cnt[6]=2; flush with concurrent issue rd=8 -> all counts 0, pending_total=0; next cycle wb rd=2 -> underflow_err=1, stays 1 through later traffic.

Source files
------------

// File: rtl/reg_write_scoreboard.sv
// Destination-register write scoreboard: per-register saturating pending counters
// feeding RAW-hazard busy flags, with flush, writeback bypass and sticky underflow.
module reg_write_scoreboard #(
  parameter int unsigned NREG      = 32,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned BYPASS_WB = 1,
  localparam int unsigned AW       = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic                issue_wen,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_rd,
  input  logic                flush,
  input  logic [AW-1:0]       rs1,
  input  logic [AW-1:0]       rs2,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic [CNT_W+AW-1:0] pending_total,
  output logic                underflow_err
);

  localparam int unsigned PW    = CNT_W + AW;
  localparam int unsigned NSLOT = 1 << AW;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [1:NREG-1];
  logic [CNT_W-1:0] cnt_d [1:NREG-1];
  logic [CNT_W-1:0] cnt_v [NSLOT];
  logic [PW-1:0]    pending_q, pending_d;
  logic             err_q, err_d;

  logic             iss_hit, wb_same, issue_fire;
  logic             wb_nz, wb_fire, wb_under;
  logic [CNT_W-1:0] cnt_rs1, cnt_rs2;
  logic             rs1_byp, rs2_byp;

  // Read view indexed by any register number; x0 and unused slots read as zero.
  always_comb begin
    for (int i = 0; i < int'(NSLOT); i++) cnt_v[i] = '0;
    for (int i = 1; i < int'(NREG); i++) cnt_v[i] = cnt_q[i];
  end

  assign iss_hit     = issue_valid && issue_wen && (issue_rd != '0);
  assign wb_same     = wb_valid && (wb_rd == issue_rd);
  assign issue_ready = !(iss_hit && (cnt_v[issue_rd] == CNT_MAX) && !wb_same);
  assign issue_fire  = iss_hit && issue_ready;

  assign wb_nz    = wb_valid && (wb_rd != '0);
  assign wb_fire  = wb_nz && (cnt_v[wb_rd] != '0);
  assign wb_under = wb_nz && (cnt_v[wb_rd] == '0);

  assign cnt_rs1  = cnt_v[rs1];
  assign cnt_rs2  = cnt_v[rs2];
  // A retiring last write releases the source in the same cycle when bypass is on.
  assign rs1_byp  = (BYPASS_WB != 0) && wb_valid && (wb_rd == rs1) && (cnt_rs1 == CNT_ONE);
  assign rs2_byp  = (BYPASS_WB != 0) && wb_valid && (wb_rd == rs2) && (cnt_rs2 == CNT_ONE);
  assign rs1_busy = (rs1 != '0) && (cnt_rs1 != '0) && !rs1_byp;
  assign rs2_busy = (rs2 != '0) && (cnt_rs2 != '0) && !rs2_byp;

  // Next-state: flush wins; a matched issue+writeback on one register cancels out.
  always_comb begin
    for (int i = 1; i < int'(NREG); i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if (issue_fire && (issue_rd == AW'(i)) && !(wb_fire && (wb_rd == AW'(i)))) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (wb_fire && (wb_rd == AW'(i)) && !(issue_fire && (issue_rd == AW'(i)))) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
    pending_d = flush ? '0 : (pending_q + PW'(issue_fire) - PW'(wb_fire));
    err_d     = err_q || (wb_under && !flush);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < int'(NREG); i++) cnt_q[i] <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 1; i < int'(NREG); i++) cnt_q[i] <= cnt_d[i];
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign pending_total = pending_q;
  assign underflow_err = err_q;

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Directed-vector bench for reg_write_scoreboard; a second instance without
// writeback bypass shares all inputs to show the one-cycle-later release.
module tb_reg_write_scoreboard;

  localparam int unsigned NREG  = 32;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned AW    = 5;

  logic          clk, reset;
  logic          issue_valid, issue_wen, wb_valid, flush;
  logic [AW-1:0] issue_rd, wb_rd, rs1, rs2;
  logic          issue_ready, rs1_busy, rs2_busy, underflow_err;
  logic [CNT_W+AW-1:0] pending_total;
  logic          nb_issue_ready, nb_rs1_busy, nb_rs2_busy, nb_underflow_err;
  logic [CNT_W+AW-1:0] nb_pending_total;

  reg_write_scoreboard #(.NREG(NREG), .CNT_W(CNT_W), .BYPASS_WB(1)) u_dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .pending_total(pending_total), .underflow_err(underflow_err)
  );

  reg_write_scoreboard #(.NREG(NREG), .CNT_W(CNT_W), .BYPASS_WB(0)) u_nb (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_ready(nb_issue_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .rs1(rs1), .rs2(rs2), .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy),
    .pending_total(nb_pending_total), .underflow_err(nb_underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int iv, iw, ird, wv, wrd, fl, r1, r2;
    int e_rdy, e_b1, e_b2, e_tot, e_err, e_nb1;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(int iv, int iw, int ird, int wv, int wrd, int fl, int r1, int r2,
                              int e_rdy, int e_b1, int e_b2, int e_tot, int e_err, int e_nb1);
    vec_t v;
    v.iv = iv; v.iw = iw; v.ird = ird; v.wv = wv; v.wrd = wrd; v.fl = fl; v.r1 = r1; v.r2 = r2;
    v.e_rdy = e_rdy; v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_tot = e_tot; v.e_err = e_err; v.e_nb1 = e_nb1;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s (row %0d) at %0t: got %0d, expected %0d", name, row, $time, act, exp);
    end
  endtask

  task automatic drive(input int iv, input int iw, input int ird, input int wv, input int wrd,
                       input int fl, input int r1, input int r2);
    issue_valid = iv[0]; issue_wen = iw[0]; issue_rd = AW'(ird);
    wb_valid = wv[0]; wb_rd = AW'(wrd); flush = fl[0]; rs1 = AW'(r1); rs2 = AW'(r2);
  endtask

  task automatic check_outs(input int row, input int rdy, input int b1, input int b2,
                            input int tot, input int err, input int nb1);
    chk("issue_ready", row, int'(issue_ready), rdy);
    chk("rs1_busy", row, int'(rs1_busy), b1);
    chk("rs2_busy", row, int'(rs2_busy), b2);
    chk("pending_total", row, int'(pending_total), tot);
    chk("underflow_err", row, int'(underflow_err), err);
    chk("nobypass_rs1_busy", row, int'(nb_rs1_busy), nb1);
  endtask

  initial begin
    // Outputs are checked in the cycle the inputs are applied, before the next edge.
    //              iv iw ird wv wrd fl r1 r2  rdy b1 b2 tot err nb1
    vecs.push_back(mk(1, 1, 7, 0, 0, 0, 7, 0,  1, 0, 0, 0, 0, 0)); // 0 issue x7
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 7, 7,  1, 1, 1, 1, 0, 1)); // 1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 7, 0,  1, 1, 0, 1, 0, 1)); // 2
    vecs.push_back(mk(0, 0, 0, 1, 7, 0, 7, 0,  1, 0, 0, 1, 0, 1)); // 3 wb x7, bypass
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 7, 0,  1, 0, 0, 0, 0, 0)); // 4 wb x0: no underflow
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 3, 0,  1, 0, 0, 0, 0, 0)); // 5 saturate x3
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 3, 0,  1, 1, 0, 1, 0, 1)); // 6
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 3, 0,  1, 1, 0, 2, 0, 1)); // 7
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 3, 0,  0, 1, 0, 3, 0, 1)); // 8 full: stall
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0,  1, 1, 0, 3, 0, 1)); // 9
    vecs.push_back(mk(1, 1, 3, 1, 3, 0, 3, 0,  1, 1, 0, 3, 0, 1)); // 10 full + wb frees slot
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0,  1, 1, 0, 3, 0, 1)); // 11
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 4,  1, 0, 0, 3, 0, 0)); // 12 issue x0
    vecs.push_back(mk(1, 0, 4, 0, 0, 0, 4, 0,  1, 0, 0, 3, 0, 0)); // 13 non-writing
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4, 0,  1, 0, 0, 3, 0, 0)); // 14
    vecs.push_back(mk(1, 0, 3, 0, 0, 0, 3, 0,  1, 1, 0, 3, 0, 1)); // 15 non-writing to full x3
    vecs.push_back(mk(1, 1, 9, 0, 0, 0, 9, 0,  1, 0, 0, 3, 0, 0)); // 16
    vecs.push_back(mk(1, 1, 9, 1, 9, 0, 9, 9,  1, 0, 0, 4, 0, 1)); // 17 issue+wb same reg
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 9, 0,  1, 1, 0, 4, 0, 1)); // 18
    vecs.push_back(mk(1, 1, 10, 0, 0, 0, 10, 0, 1, 0, 0, 4, 0, 0)); // 19
    vecs.push_back(mk(1, 1, 9, 1, 10, 0, 9, 10, 1, 1, 0, 5, 0, 1)); // 20 issue x9, wb x10
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 9, 10, 1, 1, 0, 5, 0, 1)); // 21
    vecs.push_back(mk(1, 1, 2, 0, 0, 0, 2, 0,  1, 0, 0, 5, 0, 0)); // 22
    vecs.push_back(mk(1, 1, 6, 0, 0, 0, 2, 0,  1, 1, 0, 6, 0, 1)); // 23
    vecs.push_back(mk(1, 1, 6, 0, 0, 0, 6, 2,  1, 1, 1, 7, 0, 1)); // 24
    vecs.push_back(mk(1, 1, 8, 1, 4, 1, 6, 3,  1, 1, 1, 8, 0, 1)); // 25 flush + issue + stray wb
    vecs.push_back(mk(0, 0, 0, 1, 2, 0, 8, 6,  1, 0, 0, 0, 0, 0)); // 26 late wb x2: underflow
    vecs.push_back(mk(1, 1, 5, 0, 0, 0, 2, 0,  1, 0, 0, 0, 1, 0)); // 27
    vecs.push_back(mk(0, 0, 0, 1, 5, 0, 5, 0,  1, 0, 0, 1, 1, 1)); // 28
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5, 0,  1, 0, 0, 0, 1, 0)); // 29 sticky

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_outs(-1, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].iv, vecs[k].iw, vecs[k].ird, vecs[k].wv, vecs[k].wrd, vecs[k].fl,
            vecs[k].r1, vecs[k].r2);
      #1;
      check_outs(k, vecs[k].e_rdy, vecs[k].e_b1, vecs[k].e_b2, vecs[k].e_tot,
                 vecs[k].e_err, vecs[k].e_nb1);
    end

    // Mid-run asynchronous reset with x5 holding two pending writes.
    @(negedge clk); drive(1, 1, 5, 0, 0, 0, 0, 0);
    @(negedge clk); drive(1, 1, 5, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 5, 5);
    #1;
    check_outs(100, 1, 1, 1, 2, 1, 1);
    #1 reset = 1'b1;
    #1;
    check_outs(101, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 1, 5, 0, 0, 0, 5, 0);
    #1;
    check_outs(102, 1, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 5, 0);
    #1;
    check_outs(103, 1, 1, 0, 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
